// File: rtl/imem_responder.sv
// Instruction-fetch responder: direct-mapped read-only cache with 32-byte lines,
// refilled over a 64-bit burst port. Hits answer one cycle after acceptance.
//
// state   | meaning
// IDLE    | no request outstanding, ready to accept
// COMPARE | tag lookup of req_addr; respond on hit
// BREQ    | refill request held on bmem until accepted
// FILL    | collecting refill beats into the line
module imem_responder #(
  parameter int NUM_SETS  = 16,
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic        imem_read,
  input  logic        input_valid,
  input  logic        flush,
  output logic        imem_stall,
  output logic        imem_resp,
  output logic [31:0] imem_rdata,
  output logic [31:0] imem_raddr,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  input  logic        bmem_ready,
  input  logic        bmem_rvalid,
  input  logic [63:0] bmem_rdata
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] BREQ    = 2'd2;
  localparam logic [1:0] FILL    = 2'd3;

  logic [1:0]       state;
  logic [31:0]      req_addr;
  logic [CNT_W-1:0] beat_cnt;
  logic             kill;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [NUM_SETS];
  logic [63:0]      data_q [NUM_SETS][BURST_LEN];
  logic [31:0]      rdata_q;
  logic [31:0]      raddr_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [63:0]      sel_beat;
  logic [31:0]      sel_word;
  logic             hit;
  logic             accept;
  logic             last_beat;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = &{1'b0, imem_addr[1:0]};

  assign req_idx   = req_addr[5 +: IDX_W];
  assign req_tag   = req_addr[31 -: TAG_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign sel_beat  = data_q[req_idx][req_addr[4:3]];
  assign sel_word  = req_addr[2] ? sel_beat[63:32] : sel_beat[31:0];
  assign last_beat = bmem_rvalid && (beat_cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    imem_stall = 1'b1;
    case (state)
      IDLE:    imem_stall = 1'b0;
      COMPARE: imem_stall = !hit;
      default: imem_stall = 1'b1;
    endcase
  end

  assign accept     = imem_read && input_valid && !imem_stall && !flush;
  assign imem_resp  = (state == COMPARE) && hit && !flush;
  // Response fields pass the lookup through on the resp cycle and hold afterwards.
  assign imem_rdata = imem_resp ? sel_word : rdata_q;
  assign imem_raddr = imem_resp ? req_addr : raddr_q;
  assign bmem_read  = (state == BREQ);
  assign bmem_addr  = {req_addr[31:5], 5'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      beat_cnt <= '0;
      kill     <= 1'b0;
      valid_q  <= '0;
      rdata_q  <= '0;
      raddr_q  <= '0;
    end else begin
      if (imem_resp) begin
        rdata_q <= sel_word;
        raddr_q <= req_addr;
      end
      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (accept) begin
            req_addr <= {imem_addr[31:2], 2'b00};
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          if (flush) begin
            state <= IDLE;
          end else if (hit) begin
            if (accept) req_addr <= {imem_addr[31:2], 2'b00};
            else        state    <= IDLE;
          end else begin
            state <= BREQ;
          end
        end
        BREQ: begin
          if (flush) kill <= 1'b1;
          if (bmem_ready) begin
            state    <= FILL;
            beat_cnt <= '0;
          end
        end
        default: begin
          if (flush) kill <= 1'b1;
          if (bmem_rvalid) beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) begin
            valid_q[req_idx] <= 1'b1;
            // A killed refill still installs the line but returns nothing.
            if (kill || flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else begin
              state <= COMPARE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL && bmem_rvalid) begin
      data_q[req_idx][beat_cnt] <= bmem_rdata;
      if (last_beat) tag_q[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: expected responses are queued when a
// request is driven and checked when imem_resp pulses.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        input_valid;
  logic        flush;
  logic        imem_stall;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic [31:0] imem_raddr;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_ready;
  logic        bmem_rvalid;
  logic [63:0] bmem_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  imem_responder #(.NUM_SETS(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_read(imem_read), .input_valid(input_valid),
    .flush(flush), .imem_stall(imem_stall), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .imem_raddr(imem_raddr),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_ready(bmem_ready),
    .bmem_rvalid(bmem_rvalid), .bmem_rdata(bmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0000_0093;
    if (a == 32'h0000_1004) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] line, input int k);
    logic [31:0] base;
    base = line + 32'(8 * k);
    return {word_of(base + 32'd4), word_of(base)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample 2ns after the negedge where inputs were set, scoreboard any resp, move on.
  task automatic tick();
    logic [63:0] e;
    #2;
    if (imem_resp === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", {63'd0, imem_resp}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_raddr", {32'd0, imem_raddr}, {32'd0, e[63:32]});
        chk("resp_rdata", {32'd0, imem_rdata}, {32'd0, e[31:0]});
      end
    end
    @(negedge clk);
  endtask

  task automatic req(input logic [31:0] a, input bit push);
    imem_addr   = a;
    imem_read   = 1'b1;
    input_valid = 1'b1;
    if (push) exp_q.push_back({a & 32'hFFFF_FFFC, word_of(a & 32'hFFFF_FFFC)});
  endtask

  task automatic no_req();
    imem_read   = 1'b0;
    input_valid = 1'b0;
  endtask

  // Serve one refill; flush_k / rst_k select the beat at which flush / reset hit.
  task automatic refill(input logic [31:0] line, input int flush_k, input int rst_k);
    int w;
    no_req();
    #1 chk("miss_stall", {63'd0, imem_stall}, 64'd1);
    w = 0;
    while (bmem_read !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    chk("breq_seen", {63'd0, bmem_read}, 64'd1);
    chk("bmem_addr", {32'd0, bmem_addr}, {32'd0, line});
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        bmem_rvalid = 1'b0;
        flush       = 1'b0;
        #1 chk("fill_gap_stall", {63'd0, imem_stall}, 64'd1);
        tick();
      end
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat_of(line, k);
      flush       = (k == flush_k);
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        chk("rst_bmem_read", {63'd0, bmem_read}, 64'd0);
        chk("rst_resp", {63'd0, imem_resp}, 64'd0);
        chk("rst_raddr", {32'd0, imem_raddr}, 64'd0);
        chk("rst_rdata", {32'd0, imem_rdata}, 64'd0);
        chk("rst_stall", {63'd0, imem_stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = beat_of(line, s + 1);
          #1 chk("stray_bmem_read", {63'd0, bmem_read}, 64'd0);
          tick();
        end
        bmem_rvalid = 1'b0;
        return;
      end
      #1 chk("fill_stall", {63'd0, imem_stall}, 64'd1);
      tick();
    end
    bmem_rvalid = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_addr = '0; imem_read = 1'b0; input_valid = 1'b0; flush = 1'b0;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_rdata = '0;
    @(negedge clk);
    #1;
    chk("reset_resp", {63'd0, imem_resp}, 64'd0);
    chk("reset_stall", {63'd0, imem_stall}, 64'd0);
    chk("reset_bmem_read", {63'd0, bmem_read}, 64'd0);
    chk("reset_bmem_addr", {32'd0, bmem_addr}, 64'd0);
    chk("reset_rdata", {32'd0, imem_rdata}, 64'd0);
    chk("reset_raddr", {32'd0, imem_raddr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // cold miss on 0x1004
    req(32'h0000_1004, 1'b1);
    tick();
    refill(32'h0000_1000, -1, -1);
    #2 chk("cold_resp_latency", {63'd0, imem_resp}, 64'd1);
    tick();

    // streaming hits
    req(32'h0000_1000, 1'b1);
    #1 chk("stream_stall0", {63'd0, imem_stall}, 64'd0);
    tick();
    req(32'h0000_1008, 1'b1);
    #1 chk("stream_stall1", {63'd0, imem_stall}, 64'd0);
    chk("stream_resp1", {63'd0, imem_resp}, 64'd1);
    tick();
    req(32'h0000_101C, 1'b1);
    #1 chk("stream_stall2", {63'd0, imem_stall}, 64'd0);
    chk("stream_resp2", {63'd0, imem_resp}, 64'd1);
    tick();
    no_req();
    #1 chk("stream_resp3", {63'd0, imem_resp}, 64'd1);
    chk("stream_no_breq", {63'd0, bmem_read}, 64'd0);
    tick();
    tick();

    // conflict eviction 0x1200 then 0x1000 again
    req(32'h0000_1200, 1'b1);
    tick();
    refill(32'h0000_1200, -1, -1);
    #2 chk("evict_resp", {63'd0, imem_resp}, 64'd1);
    tick();
    req(32'h0000_1000, 1'b1);
    tick();
    refill(32'h0000_1000, -1, -1);
    #2 chk("refetch_resp", {63'd0, imem_resp}, 64'd1);
    tick();

    // flush mid-fill on 0x2000
    req(32'h0000_2000, 1'b0);
    tick();
    refill(32'h0000_2000, 1, -1);
    #2;
    chk("flush_no_resp", {63'd0, imem_resp}, 64'd0);
    chk("flush_idle_stall", {63'd0, imem_stall}, 64'd0);
    tick();
    req(32'h0000_2000, 1'b1);
    tick();
    no_req();
    #2 chk("flush_then_hit", {63'd0, imem_resp}, 64'd1);
    chk("flush_hit_no_breq", {63'd0, bmem_read}, 64'd0);
    tick();
    tick();

    // reset mid-fill on 0x3000
    req(32'h0000_3000, 1'b0);
    tick();
    refill(32'h0000_3000, -1, 0);
    req(32'h0000_3000, 1'b1);
    tick();
    refill(32'h0000_3000, -1, -1);
    #2 chk("post_rst_resp", {63'd0, imem_resp}, 64'd1);
    tick();
    tick();

    // qualifier low
    for (int i = 0; i < 5; i++) begin
      imem_addr   = 32'h0000_1000;
      imem_read   = 1'b1;
      input_valid = 1'b0;
      #1;
      chk("qual_resp", {63'd0, imem_resp}, 64'd0);
      chk("qual_stall", {63'd0, imem_stall}, 64'd0);
      chk("qual_breq", {63'd0, bmem_read}, 64'd0);
      tick();
    end
    no_req();
    tick();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
